// File: rtl/microsequencer_next_state.sv
// -----------------------------------------------------------------------------
// microsequencer_next_state
//
// Registered next-state engine for a microprogrammed control unit. Each cycle
// it combines the control fields of the active control word, the condition
// inputs and the encoder entry state into a candidate next state. It then
// applies the memory-wait timeout and the illegal-state guard, and registers
// the result. current_state feeds the control-word lookup.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   n_sel[2:0]     next-state mode field
//   inv            inverts the selected condition
//   s_sel[1:0]     condition select: 00 moc, 01 cond, 10 const 0, 11 const 1
//   cr_state       jump target field of the control word
//   enc_state      entry state from the instruction encoder
//   moc            memory operation complete
//   cond           branch condition from the condition tester
//   current_state  registered control state
//   stalled        high while the previous cycle was a wait-repeat
//   mem_timeout    one-cycle pulse: wait aborted by timeout
//   illegal_state  one-cycle pulse: candidate exceeded LAST_STATE
// -----------------------------------------------------------------------------
module microsequencer_next_state #(
    parameter int STATE_W     = 7,
    parameter int LAST_STATE  = 44,
    parameter int RESET_STATE = 0,
    parameter int MOC_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         s_sel,
    input  logic [STATE_W-1:0] cr_state,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] current_state,
    output logic               stalled,
    output logic               mem_timeout,
    output logic               illegal_state
);

    // The stall counter only has to reach MOC_TIMEOUT-1, because the repeat
    // at that count aborts the wait. With the timeout disabled, the counter
    // saturates instead of wrapping.
    localparam int CNT_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
    localparam bit TIMEOUT_EN = (MOC_TIMEOUT > 0);

    localparam logic [STATE_W-1:0] LAST_S    = STATE_W'(LAST_STATE);
    localparam logic [STATE_W-1:0] RESET_S   = STATE_W'(RESET_STATE);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT_EN ? MOC_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stalled_q, stalled_d;
    logic               timeout_q, timeout_d;
    logic               illegal_q, illegal_d;

    logic               sel_cond;
    logic               c;
    logic [STATE_W-1:0] inc_state;
    logic [STATE_W-1:0] candidate;
    logic               is_repeat;
    logic               timeout_hit;

    always_comb begin
        sel_cond = 1'b0;
        case (s_sel)
            2'b00:   sel_cond = moc;
            2'b01:   sel_cond = cond;
            default: sel_cond = s_sel[0];
        endcase
        c = sel_cond ^ inv;

        // A wrap here is harmless: current_state never exceeds LAST_STATE.
        // LAST_STATE+1 is caught by the guard below.
        inc_state = state_q + STATE_W'(1);

        candidate = state_q;
        case (n_sel)
            3'b000:  candidate = enc_state;
            3'b001:  candidate = RESET_S;
            3'b010:  candidate = cr_state;
            3'b011:  candidate = c ? cr_state : inc_state;
            3'b100:  candidate = c ? cr_state : enc_state;
            3'b101:  candidate = inc_state;
            3'b110:  candidate = c ? inc_state : state_q;
            default: candidate = c ? enc_state : state_q;
        endcase

        // Modes 110/111 with a false condition hold the current state.
        is_repeat   = n_sel[2] & n_sel[1] & ~c;
        timeout_hit = TIMEOUT_EN && is_repeat && (cnt_q == CNT_LIMIT);
    end

    // Next-state resolution. Priority: timeout > illegal guard > candidate.
    // Reset is applied in the register block.
    always_comb begin
        state_d   = candidate;
        cnt_d     = '0;
        stalled_d = 1'b0;
        timeout_d = 1'b0;
        illegal_d = 1'b0;

        if (timeout_hit) begin
            state_d   = RESET_S;
            timeout_d = 1'b1;
        end else begin
            if (is_repeat) begin
                cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                stalled_d = 1'b1;
            end
            if (candidate > LAST_S) begin
                state_d   = RESET_S;
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_S;
            cnt_q     <= '0;
            stalled_q <= 1'b0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    assign current_state = state_q;
    assign stalled       = stalled_q;
    assign mem_timeout   = timeout_q;
    assign illegal_state = illegal_q;

endmodule

// File: tb/tb_microsequencer_next_state.sv
// -----------------------------------------------------------------------------
// Testbench for microsequencer_next_state (MOC_TIMEOUT overridden to 4).
// The driver applies one set of inputs per cycle at the falling edge. It then
// advances a behavioural model and pushes the expected registered outputs into
// a queue. The monitor pops one entry after every rising edge and compares it
// with the outputs of the design.
// -----------------------------------------------------------------------------
module tb_microsequencer_next_state;

    localparam int SW   = 7;
    localparam int LAST = 44;
    localparam int RST  = 0;
    localparam int TO   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    n_sel;
    logic          inv;
    logic [1:0]    s_sel;
    logic [SW-1:0] cr_state;
    logic [SW-1:0] enc_state;
    logic          moc;
    logic          cond;
    logic [SW-1:0] current_state;
    logic          stalled;
    logic          mem_timeout;
    logic          illegal_state;

    microsequencer_next_state #(
        .STATE_W(SW), .LAST_STATE(LAST), .RESET_STATE(RST), .MOC_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .n_sel(n_sel), .inv(inv), .s_sel(s_sel),
        .cr_state(cr_state), .enc_state(enc_state), .moc(moc), .cond(cond),
        .current_state(current_state), .stalled(stalled),
        .mem_timeout(mem_timeout), .illegal_state(illegal_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state;
        bit stl;
        bit tmo;
        bit ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    // Behavioural model state
    int m_state = RST;
    int m_wait  = 0;   // consecutive repeats so far

    // Drive one cycle of inputs, predict the response, and queue the prediction.
    task automatic step(input bit r, input int n, input bit iv, input int s,
                        input int cr, input int enc, input bit m, input bit cd);
        exp_t e;
        bit   cv;
        bit   rep;
        int   cand;
        @(negedge clk);
        reset     = r;
        n_sel     = 3'(n);
        inv       = iv;
        s_sel     = 2'(s);
        cr_state  = 7'(cr);
        enc_state = 7'(enc);
        moc       = m;
        cond      = cd;

        e = '{state: 0, stl: 0, tmo: 0, ill: 0};
        if (r) begin
            m_state = RST;
            m_wait  = 0;
        end else begin
            if (s == 0)      cv = m;
            else if (s == 1) cv = cd;
            else             cv = (s == 3);
            cv = cv ^ iv;
            // The result is the next state if the wait has not ended.
            // The wait has not ended when it is in a wait mode and the
            // condition is false.
            rep = (n >= 6) && !cv;
            if (rep && TO > 0 && m_wait + 1 >= TO) begin
                m_state = RST;
                m_wait  = 0;
                e.tmo   = 1;
            end else begin
                case (n)
                    0: cand = enc;
                    1: cand = RST;
                    2: cand = cr;
                    3: cand = cv ? cr : (m_state + 1) % 128;
                    4: cand = cv ? cr : enc;
                    5: cand = (m_state + 1) % 128;
                    6: cand = cv ? (m_state + 1) % 128 : m_state;
                    default: cand = cv ? enc : m_state;
                endcase
                m_wait = rep ? m_wait + 1 : 0;
                e.stl  = rep;
                if (cand > LAST) begin
                    m_state = RST;
                    e.ill   = 1;
                end else begin
                    m_state = cand;
                end
            end
        end
        e.state = m_state;
        exp_q.push_back(e);
    endtask

    task automatic load(input int s);
        step(0, 2, 0, 2, s, 0, 0, 0);
    endtask

    // Monitor: one comparison per transaction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            n_checks++;
            if (int'(current_state) != e.state || stalled !== e.stl ||
                mem_timeout !== e.tmo || illegal_state !== e.ill) begin
                n_fail++;
                $display("FAIL txn %0d: got state=%0d stalled=%b timeout=%b illegal=%b, want state=%0d stalled=%b timeout=%b illegal=%b",
                         txn, current_state, stalled, mem_timeout, illegal_state,
                         e.state, e.stl, e.tmo, e.ill);
            end else begin
                $display("txn %0d ok: state=%0d stalled=%b timeout=%b illegal=%b",
                         txn, current_state, stalled, mem_timeout, illegal_state);
            end
        end
    end

    initial begin
        reset = 1'b1; n_sel = '0; inv = 1'b0; s_sel = '0;
        cr_state = '0; enc_state = '0; moc = 1'b0; cond = 1'b0;

        // Reset from an arbitrary state, then release into an encoder dispatch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        load(17);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 6, 0, 0);

        // Increment and jump
        load(7);
        step(0, 5, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 12, 0, 0, 0);

        // Conditional branch, condition taken and inverted
        load(20);
        step(0, 3, 0, 1, 30, 0, 0, 1);
        load(20);
        step(0, 3, 1, 1, 30, 0, 0, 1);

        // Memory wait: three repeats, then completion
        load(2);
        repeat (3) step(0, 6, 0, 0, 0, 0, 0, 0);
        step(0, 6, 0, 0, 0, 0, 1, 0);

        // Timeout after TO stall cycles, then a back-to-back second timeout
        load(9);
        repeat (4) step(0, 6, 0, 0, 0, 0, 0, 0);
        load(9);
        repeat (4) step(0, 7, 0, 0, 0, 0, 0, 0);

        // Reset mid-stall at count 2: no timeout pulse, and the counter restarts
        load(9);
        repeat (2) step(0, 6, 0, 0, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0, 0, 0);
        load(9);
        repeat (3) step(0, 6, 0, 0, 0, 0, 0, 0);

        // Illegal guard: increment past LAST, jump beyond, and repeated pulses
        load(44);
        step(0, 5, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 100, 0, 0, 0);
        step(0, 2, 0, 0, 100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 45, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int n, cr, enc;
            n   = ($urandom_range(0, 3) == 0) ? 6 + int'($urandom_range(0, 1))
                                              : int'($urandom_range(0, 7));
            cr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, LAST));
            enc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, LAST));
            step(bit'($urandom_range(0, 59) == 0), n, bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), cr, enc,
                 bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 1)));
        end

        // Let the monitor drain the queue, with a bounded wait
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected transactions left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/microsequencer_next_state.md
Name: microsequencer_next_state

Overview:
- Registered next-state engine for the microprogrammed control unit.
- Each cycle it takes the control fields of the active control word, the condition inputs and the decoder-supplied entry state, and computes the next control state.
- Its current_state output drives the control-word lookup.
- Provides increment, jump, encoder dispatch, conditional branch and memory-wait stall, plus a memory-wait timeout and an illegal-state guard.

Parameters:
STATE_W, 7, width of the state number
LAST_STATE, 44, highest legal state; any candidate above this is illegal
RESET_STATE, 0, state entered on reset, timeout or illegal candidate
MOC_TIMEOUT, 16, maximum consecutive stall cycles before abort; 0 disables the timeout

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
n_sel  input  3  next-state mode field of the active control word
inv  input  1  inverts the selected condition
s_sel  input  2  condition select: 00 moc, 01 cond, 10 constant 0, 11 constant 1
cr_state  input  STATE_W  jump target field of the active control word
enc_state  input  STATE_W  entry state from the instruction encoder
moc  input  1  memory operation complete
cond  input  1  branch condition from the condition tester
current_state  output  STATE_W  registered control state
stalled  output  1  high while the previous cycle was a wait-repeat
mem_timeout  output  1  one-cycle pulse: wait aborted by timeout
illegal_state  output  1  one-cycle pulse: candidate exceeded LAST_STATE

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Reset (sampled at posedge clk):
  - current_state=RESET_STATE
  - stall counter=0
  - stalled=0, mem_timeout=0, illegal_state=0
  - Reset overrides every other input, including mid-stall.
- Condition: c = (s_sel==00 ? moc : s_sel==01 ? cond : s_sel[0]) XOR inv.
- Candidate next state (combinational) from n_sel:
  - 000: enc_state
  - 001: RESET_STATE
  - 010: cr_state
  - 011: c ? cr_state : current_state+1
  - 100: c ? cr_state : enc_state
  - 101: current_state+1
  - 110 (wait): c ? current_state+1 : current_state (repeat)
  - 111: c ? enc_state : current_state (repeat)
- Increment is STATE_W wide. current_state==LAST_STATE with an increment yields a candidate of LAST_STATE+1, which is handled by the illegal-state guard.
- Illegal-state guard: if candidate > LAST_STATE, load RESET_STATE and pulse illegal_state the same cycle the load takes effect.
- Repeat: a "repeat" is a mode-110/111 cycle with c=0. On a repeat, stall counter increments and stalled=1 next cycle. Any non-repeat cycle clears the counter and sets stalled=0.
- Timeout: if MOC_TIMEOUT>0 and a repeat occurs while counter==MOC_TIMEOUT-1:
  - load RESET_STATE
  - clear the counter
  - pulse mem_timeout for one cycle
  - stalled=0
- Priority (highest first): reset > timeout > illegal guard > normal candidate.
- Latency: fields presented in cycle k determine current_state in cycle k+1. No combinational path from inputs to outputs.
- All outputs are registered. Pulses last exactly one cycle, even if the same condition recurs immediately; each recurrence produces its own pulse.

Test Plan:
- Reset: assert reset 2 cycles from arbitrary state 17 -> current_state=0, all flags 0. Release with n_sel=000, enc_state=6 -> current_state=6 next cycle.
- Increment and jump: state 7, n_sel=101 -> 8. Then n_sel=010, cr_state=12 -> 12.
- Conditional branch: state 20, n_sel=011, s_sel=01, cr_state=30:
  - cond=1, inv=0 -> 30
  - cond=1, inv=1 -> 21
- Memory wait: state 2, n_sel=110, s_sel=00, moc=0 for 3 cycles -> holds 2, stalled=1. moc=1 -> 3, stalled=0, counter 0.
- Timeout with MOC_TIMEOUT=4: hold moc=0 at state 9 in mode 110 -> state 9 for 4 cycles, then 0 with mem_timeout pulse of 1 cycle. Reset asserted during a stall at count 2 -> state 0, no mem_timeout pulse.
- Illegal guard: state 44, n_sel=101 -> 0 with illegal_state pulse. Also n_sel=010, cr_state=100 -> 0 with illegal_state pulse.
